// File: rtl/muldiv_sequencer_if.sv
// Bundle of the request, unit and result signals of the mult/div sequencer.
// Handshake: the control unit holds mult_req/div_req as a level. The request
// is taken only while busy is low. Exactly one of done/div_zero/timeout pulses
// for one cycle to end the operation, unless abort ended it first. A unit sees
// one *_start pulse and answers with *_ready. Its hi/lo outputs only have to be
// valid in the cycle where *_ready is high.
interface muldiv_sequencer_if;
    logic        mult_req;
    logic        div_req;
    logic        abort;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] unit_a;
    logic [31:0] unit_b;
    logic        mult_start;
    logic        div_start;
    logic        mult_ready;
    logic        div_ready;
    logic [31:0] mult_hi;
    logic [31:0] mult_lo;
    logic [31:0] div_hi;
    logic [31:0] div_lo;
    logic        hi_wr;
    logic        lo_wr;
    logic [31:0] hi_data;
    logic [31:0] lo_data;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic        timeout;
    logic [2:0]  dbg_state;

    // Control unit plus the two arithmetic units.
    modport master (
        output mult_req, div_req, abort, op_a, op_b,
        output mult_ready, div_ready, mult_hi, mult_lo, div_hi, div_lo,
        input  unit_a, unit_b, mult_start, div_start,
        input  hi_wr, lo_wr, hi_data, lo_data,
        input  busy, done, div_zero, timeout, dbg_state
    );

    // The sequencer itself.
    modport slave (
        input  mult_req, div_req, abort, op_a, op_b,
        input  mult_ready, div_ready, mult_hi, mult_lo, div_hi, div_lo,
        output unit_a, unit_b, mult_start, div_start,
        output hi_wr, lo_wr, hi_data, lo_data,
        output busy, done, div_zero, timeout, dbg_state
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Runs one multiply or divide on behalf of the control unit. It latches the
// operands, pulses the chosen unit's start and waits a bounded time for ready.
// It then writes HI/LO and reports done, divide-by-zero or timeout.
module muldiv_sequencer #(
    parameter int TIMEOUT_CYCLES = 40,
    parameter int CNT_W          = 6
) (
    input  logic               clk,
    input  logic               reset,
    muldiv_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_WRITE  = 3'd3,
        S_DONE   = 3'd4,
        S_ZERO   = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic             r_is_div;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;

    logic             w_accept;
    logic             w_sel_div;
    logic             w_capture;
    logic             w_ready;

    // Only the selected unit's ready matters; the other one is ignored.
    assign w_ready = r_is_div ? bus.div_ready : bus.mult_ready;

    // Next-state decode. Abort overrides everything outside IDLE. In IDLE it
    // blocks acceptance of a coincident request.
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_sel_div = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!bus.abort) begin
                    if (bus.mult_req) begin
                        w_accept  = 1'b1;
                        w_sel_div = 1'b0;
                        w_next    = S_LAUNCH;
                    end else if (bus.div_req) begin
                        w_accept  = 1'b1;
                        w_sel_div = 1'b1;
                        w_next    = (bus.op_b == 32'd0) ? S_ZERO : S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: w_next = S_WAIT;
            S_WAIT: begin
                // A ready seen in the first WAIT cycle may be left over from
                // the previous operation, so it is not trusted.
                if (w_ready && (r_cnt != '0)) begin
                    w_capture = 1'b1;
                    w_next    = S_WRITE;
                end else if (r_cnt == LP_CNT_LAST) begin
                    w_next = S_FAULT;
                end
            end
            S_WRITE: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            S_ZERO:  w_next = S_IDLE;
            S_FAULT: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (bus.abort && (r_state != S_IDLE)) begin
            w_next    = S_IDLE;
            w_capture = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // WAIT cycle counter: cleared in LAUNCH, counts every WAIT cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_state == S_LAUNCH) begin
            r_cnt <= '0;
        end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Operand and op-select latches. They hold from one acceptance to the next.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_is_div <= 1'b0;
        end else if (w_accept) begin
            r_a      <= bus.op_a;
            r_b      <= bus.op_b;
            r_is_div <= w_sel_div;
        end
    end

    // Result registers: loaded from the selected unit when its ready is trusted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_capture) begin
            r_hi <= r_is_div ? bus.div_hi : bus.mult_hi;
            r_lo <= r_is_div ? bus.div_lo : bus.mult_lo;
        end
    end

    // Outputs decode from state and registers. Only the HI/LO write strobes
    // look at abort, so an aborted WRITE never commits.
    assign bus.unit_a     = r_a;
    assign bus.unit_b     = r_b;
    assign bus.mult_start = (r_state == S_LAUNCH) && !r_is_div;
    assign bus.div_start  = (r_state == S_LAUNCH) && r_is_div;
    assign bus.hi_wr      = (r_state == S_WRITE) && !bus.abort;
    assign bus.lo_wr      = (r_state == S_WRITE) && !bus.abort;
    assign bus.hi_data    = r_hi;
    assign bus.lo_data    = r_lo;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.done       = (r_state == S_DONE);
    assign bus.div_zero   = (r_state == S_ZERO);
    assign bus.timeout    = (r_state == S_FAULT);
    assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer. The drivers issue one request at a time. For each
// request they push the expected timestamped output events into exp_q. A
// monitor compares every output event the DUT shows against the queue head.
module tb_muldiv_sequencer;

  localparam int T = 40;
  localparam int W = 85;  // {kind[3], cycle[16], hi_wr, lo_wr, data[64]}

  localparam logic [2:0] K_MSTART = 3'd1;
  localparam logic [2:0] K_DSTART = 3'd2;
  localparam logic [2:0] K_WRITE  = 3'd3;
  localparam logic [2:0] K_DONE   = 3'd4;
  localparam logic [2:0] K_ZERO   = 3'd5;
  localparam logic [2:0] K_FAULT  = 3'd6;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  muldiv_sequencer_if bus();

  muldiv_sequencer #(.TIMEOUT_CYCLES(T), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int unit_lat = 0;
  bit unit_busy = 1'b0;

  function automatic logic [W-1:0] mk(logic [2:0] k, int c, logic [1:0] wr, logic [63:0] d);
    return {k, 16'(c), wr, d};
  endfunction

  // reference arithmetic: signed product / unsigned remainder:quotient
  function automatic logic [63:0] ref_result(bit d, logic [31:0] a, logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    if (d) return {a % b, a / b};
    sa = $signed(a);
    sb = $signed(b);
    return sa * sb;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic mon_event(input string name, input logic [W-1:0] got);
    logic [W-1:0] e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: unexpected event %h, expected none", name, got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        n_err++;
        $display("FAIL %s: got %h want %h", name, got, e);
      end
    end
  endtask

  // monitor: every output event becomes a timestamped word
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.mult_start)
        mon_event("mult_start", mk(K_MSTART, cyc, {bus.hi_wr, bus.lo_wr}, {bus.unit_a, bus.unit_b}));
      if (bus.div_start)
        mon_event("div_start", mk(K_DSTART, cyc, {bus.hi_wr, bus.lo_wr}, {bus.unit_a, bus.unit_b}));
      if (bus.hi_wr || bus.lo_wr)
        mon_event("hilo_write", mk(K_WRITE, cyc, {bus.hi_wr, bus.lo_wr}, {bus.hi_data, bus.lo_data}));
      if (bus.done)
        mon_event("done", mk(K_DONE, cyc, {bus.hi_wr, bus.lo_wr}, 64'd0));
      if (bus.div_zero)
        mon_event("div_zero", mk(K_ZERO, cyc, {bus.hi_wr, bus.lo_wr}, 64'd0));
      if (bus.timeout)
        mon_event("timeout", mk(K_FAULT, cyc, {bus.hi_wr, bus.lo_wr}, 64'd0));
    end
  end

  // arithmetic unit model: ready pulses unit_lat cycles after start (0 = never)
  initial begin
    bit d;
    logic [31:0] ua;
    logic [31:0] ub;
    logic [63:0] r;
    int l;
    bus.mult_ready = 1'b0;
    bus.div_ready  = 1'b0;
    bus.mult_hi = '0; bus.mult_lo = '0;
    bus.div_hi  = '0; bus.div_lo  = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.mult_start || bus.div_start) begin
        d  = bus.div_start;
        ua = bus.unit_a;
        ub = bus.unit_b;
        l  = unit_lat;
        if (l > 0) begin
          unit_busy = 1'b1;
          repeat (l) begin @(posedge clk); #1; end
          r = ref_result(d, ua, ub);
          if (d) begin
            bus.div_hi = r[63:32]; bus.div_lo = r[31:0]; bus.div_ready = 1'b1;
          end else begin
            bus.mult_hi = r[63:32]; bus.mult_lo = r[31:0]; bus.mult_ready = 1'b1;
          end
          @(posedge clk); #1;
          bus.mult_ready = 1'b0;
          bus.div_ready  = 1'b0;
          bus.mult_hi = $urandom; bus.mult_lo = $urandom;
          bus.div_hi  = $urandom; bus.div_lo  = $urandom;
          unit_busy = 1'b0;
        end
      end
    end
  end

  task automatic wait_unit_idle();
    for (int i = 0; i < 200 && unit_busy; i++) @(posedge clk);
    if (unit_busy) begin
      n_cmp++;
      n_err++;
      $display("FAIL unit_idle: still busy after 200 cycles, required idle");
    end
  endtask

  // One request. Cycle 0 = acceptance cycle. abort_at: cycle abort is held
  // (-1 = never). both = raise both requests.
  task automatic do_op(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                       input int lat, input int abort_at, input bit both, input bit chg);
    int base;
    int last;
    int nend;
    bit eff_div;
    logic [63:0] r;
    logic [2:0] ev_k[$];
    int ev_c[$];
    logic [1:0] ev_wr[$];
    logic [63:0] ev_d[$];

    wait_unit_idle();
    unit_lat = lat;
    @(posedge clk); #1;
    base = cyc;
    bus.op_a = a;
    bus.op_b = b;
    bus.mult_req = !is_div || both;
    bus.div_req  = is_div || both;
    bus.abort    = (abort_at == 0);

    eff_div = is_div && !both;
    last = 0;
    if (abort_at != 0) begin
      if (eff_div && b == 32'd0) begin
        ev_k.push_back(K_ZERO); ev_c.push_back(1); ev_wr.push_back(2'b00); ev_d.push_back(64'd0);
        last = 1;
      end else begin
        ev_k.push_back(eff_div ? K_DSTART : K_MSTART); ev_c.push_back(1);
        ev_wr.push_back(2'b00); ev_d.push_back({a, b});
        if (lat >= 2 && lat <= T) begin
          r = ref_result(eff_div, a, b);
          ev_k.push_back(K_WRITE); ev_c.push_back(lat + 2); ev_wr.push_back(2'b11); ev_d.push_back(r);
          ev_k.push_back(K_DONE);  ev_c.push_back(lat + 3); ev_wr.push_back(2'b00); ev_d.push_back(64'd0);
          last = lat + 3;
        end else begin
          ev_k.push_back(K_FAULT); ev_c.push_back(T + 2); ev_wr.push_back(2'b00); ev_d.push_back(64'd0);
          last = T + 2;
        end
      end
    end
    nend = last + 1;
    if (abort_at >= 1 && abort_at <= last) nend = abort_at + 1;
    for (int i = 0; i < ev_k.size(); i++) begin
      if (abort_at < 1 || abort_at > last || ev_c[i] < abort_at ||
          (ev_c[i] == abort_at && ev_k[i] != K_WRITE))
        exp_q.push_back(mk(ev_k[i], base + ev_c[i], ev_wr[i], ev_d[i]));
    end

    for (int c = 0; c <= nend; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        bus.mult_req = 1'b0;
        bus.div_req  = 1'b0;
        bus.abort    = (c == abort_at);
        if (chg && c == 1) begin
          bus.op_a = ~a;
          bus.op_b = ~b;
        end
      end
      check($sformatf("busy_c%0d", c), bus.busy, (c >= 1 && c < nend));
    end
    bus.abort = 1'b0;
    check("events_left", exp_q.size(), 0);
    exp_q.delete();
    if (abort_at != 0) check("unit_ab_held", {bus.unit_a, bus.unit_b}, {a, b});
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctl"}, {bus.busy, bus.hi_wr, bus.lo_wr, bus.done, bus.div_zero,
                           bus.timeout, bus.mult_start, bus.div_start}, 64'd0);
    check({name, "_unit"}, {bus.unit_a, bus.unit_b}, 64'd0);
    check({name, "_data"}, {bus.hi_data, bus.lo_data}, 64'd0);
  endtask

  // async reset while a multiply is in WAIT
  task automatic reset_mid_op();
    int base;
    wait_unit_idle();
    unit_lat = 10;
    @(posedge clk); #1;
    base = cyc;
    bus.op_a = 32'h1234_5678;
    bus.op_b = 32'h0000_0003;
    bus.mult_req = 1'b1;
    exp_q.push_back(mk(K_MSTART, base + 1, 2'b00, {32'h1234_5678, 32'h0000_0003}));
    @(posedge clk); #1;
    bus.mult_req = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    #2 reset = 1'b1;
    #1 check_all_zero("async_reset");
    @(posedge clk); #3;
    reset = 1'b0;
    check("reset_events_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // main stimulus
  initial begin
    bit d;
    logic [31:0] a;
    logic [31:0] b;
    int lat;
    int ab;
    reset = 1'b1;
    bus.mult_req = 1'b0;
    bus.div_req  = 1'b0;
    bus.abort    = 1'b0;
    bus.op_a     = '0;
    bus.op_b     = '0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset_state");
    reset = 1'b0;
    @(posedge clk); #1;
    check_all_zero("after_release");

    do_op(1'b0, 32'd7, 32'hFFFF_FFFD, 4, -1, 1'b0, 1'b0);   // multiply, -21
    do_op(1'b1, 32'd100, 32'd7, 5, -1, 1'b0, 1'b0);         // divide 100/7
    do_op(1'b1, 32'd55, 32'd0, 3, -1, 1'b0, 1'b0);          // divide by zero
    do_op(1'b0, 32'd3, 32'd4, 0, -1, 1'b0, 1'b0);           // unit never ready
    do_op(1'b0, 32'd3, 32'd4, T, -1, 1'b0, 1'b0);           // ready on last WAIT cycle
    do_op(1'b0, 32'd5, 32'd6, 1, -1, 1'b0, 1'b0);           // ready only in first WAIT cycle
    do_op(1'b0, 32'd9, 32'd9, 6, 3, 1'b0, 1'b0);            // abort in WAIT
    do_op(1'b1, 32'd1000, 32'd3, 5, 7, 1'b0, 1'b0);         // abort in WRITE
    do_op(1'b0, 32'd12, 32'd13, 3, -1, 1'b1, 1'b0);         // both requests
    do_op(1'b1, 32'd77, 32'd5, 6, -1, 1'b0, 1'b1);          // operands change while busy
    do_op(1'b0, 32'd1, 32'd2, 3, 0, 1'b0, 1'b0);            // abort in IDLE blocks request
    reset_mid_op();
    do_op(1'b0, 32'hDEAD_BEEF, 32'h10, 3, -1, 1'b0, 1'b0);  // normal after reset

    for (int n = 0; n < 30; n++) begin
      d = 1'($urandom_range(0, 1));
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      case ($urandom_range(0, 15))
        0:       lat = 0;
        1:       lat = 1;
        default: lat = $urandom_range(2, 12);
      endcase
      ab = ($urandom_range(0, 4) == 0) ? $urandom_range(0, lat + 3) : -1;
      do_op(d, a, b, lat, ab, ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // watchdog
  initial begin
    #1000000;
    n_cmp++;
    n_err++;
    $display("FAIL watchdog: bench still running at %0t, required finished", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
